// File: rtl/williams_blt_bus_arbiter.sv
// ============================================================================
// williams_blt_bus_arbiter: halts the 6809, then serves blitter accesses to memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module williams_blt_bus_arbiter #(
  parameter int HALT_SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_e_n_i,
  input  logic        blt_halt_i,
  output logic        blt_halt_ack_o,
  output logic        cpu_halt_o,
  input  logic        cpu_ba_i,
  input  logic        cpu_bs_i,
  output logic        bus_owner_o,
  input  logic        blt_rd_i,
  input  logic        blt_wr_i,
  input  logic [15:0] blt_address_i,
  input  logic [7:0]  blt_wdata_i,
  input  logic [1:0]  blt_nibble_en_i,
  output logic [7:0]  blt_rdata_o,
  output logic        blt_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic [1:0]  mem_wmask_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HALT_REQ = 3'd1;
  localparam logic [2:0] ST_GRANTED  = 3'd2;
  localparam logic [2:0] ST_ACCESS   = 3'd3;
  localparam logic [2:0] ST_ACK      = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(HALT_SETTLE - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  wmask_q, wmask_d;
  logic        we_q, we_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        w_cpu_halted;
  logic        w_access;

  assign w_cpu_halted = cpu_ba_i && cpu_bs_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= 4'd0;
      addr_q   <= 16'd0;
      wdata_q  <= 8'd0;
      wmask_q  <= 2'b00;
      we_q     <= 1'b0;
      rdata_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_IDLE: begin
        settle_d = 4'd0;
        if (blt_halt_i) begin
          state_d = ST_HALT_REQ;
        end
      end
      ST_HALT_REQ: begin
        if (!blt_halt_i) begin
          state_d  = ST_IDLE;
          settle_d = 4'd0;
        end else if (en_e_n_i) begin
          // Any strobe without BA/BS restarts the settle window.
          if (w_cpu_halted) begin
            settle_d = settle_q + 4'd1;
            if (settle_q == SETTLE_LAST) begin
              state_d = ST_GRANTED;
            end
          end else begin
            settle_d = 4'd0;
          end
        end
      end
      ST_GRANTED: begin
        if (!blt_halt_i) begin
          state_d = ST_IDLE;
        end else if (blt_rd_i) begin
          addr_d  = blt_address_i;
          wmask_d = 2'b00;
          we_d    = 1'b0;
          state_d = ST_ACCESS;
        end else if (blt_wr_i) begin
          if (blt_nibble_en_i == 2'b00) begin
            state_d = ST_ACK;
          end else begin
            addr_d  = blt_address_i;
            wdata_d = blt_wdata_i;
            wmask_d = blt_nibble_en_i;
            we_d    = 1'b1;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ready_i) begin
          if (!we_q) begin
            rdata_d = mem_rdata_i;
          end
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (en_e_n_i) begin
          state_d = blt_halt_i ? ST_GRANTED : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign w_access = (state_q == ST_ACCESS);

  always_comb begin
    cpu_halt_o     = (state_q != ST_IDLE);
    blt_halt_ack_o = (state_q == ST_GRANTED) || w_access || (state_q == ST_ACK);
    bus_owner_o    = blt_halt_ack_o;
    blt_ack_o      = (state_q == ST_ACK);
    mem_req_o      = w_access;
    mem_we_o       = w_access && we_q;
    mem_addr_o     = w_access ? addr_q  : 16'd0;
    mem_wdata_o    = w_access ? wdata_q : 8'd0;
    mem_wmask_o    = w_access ? wmask_q : 2'b00;
    blt_rdata_o    = rdata_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_williams_blt_bus_arbiter.sv
// ============================================================================
// tb_williams_blt_bus_arbiter: directed handshakes plus randomized scoreboard run
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_williams_blt_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_e_n;
  logic        strobe_auto = 1'b0;
  logic        strobe_man = 1'b0;
  logic        auto_q = 1'b0;
  logic        blt_halt = 1'b0;
  logic        ba = 1'b0;
  logic        bs = 1'b0;
  logic        blt_rd = 1'b0;
  logic        blt_wr = 1'b0;
  logic [15:0] blt_address = 16'd0;
  logic [7:0]  blt_wdata = 8'd0;
  logic [1:0]  blt_nib = 2'b00;
  logic        blt_halt_ack, cpu_halt, bus_owner, blt_ack, mem_req, mem_we;
  logic [7:0]  blt_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic [1:0]  mem_wmask;
  logic        mem_ready = 1'b0;

  logic [7:0]  tbmem  [0:65535];
  logic [7:0]  refmem [0:65535];
  bit          init_done = 1'b0;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } mem_t;

  mem_t        mem_q[$];
  logic [7:0]  ack_q[$];
  bit          sb_en = 1'b0;
  int          wait_min = 0;
  int          wait_max = 0;
  int          wcnt = 0;
  int          cur_wait = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  last_rd = 8'd0;

  assign en_e_n    = strobe_auto ? auto_q : strobe_man;
  assign mem_rdata = tbmem[mem_addr];

  williams_blt_bus_arbiter #(.HALT_SETTLE(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_e_n_i       (en_e_n),
    .blt_halt_i     (blt_halt),
    .blt_halt_ack_o (blt_halt_ack),
    .cpu_halt_o     (cpu_halt),
    .cpu_ba_i       (ba),
    .cpu_bs_i       (bs),
    .bus_owner_o    (bus_owner),
    .blt_rd_i       (blt_rd),
    .blt_wr_i       (blt_wr),
    .blt_address_i  (blt_address),
    .blt_wdata_i    (blt_wdata),
    .blt_nibble_en_i(blt_nib),
    .blt_rdata_o    (blt_rdata),
    .blt_ack_o      (blt_ack),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_wmask_o    (mem_wmask),
    .mem_rdata_i    (mem_rdata),
    .mem_ready_i    (mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(int a);
    if (a == 16'h9A40) return 8'h5C;
    return 8'((a * 37) ^ (a >> 5) ^ 8'h3C);
  endfunction

  function automatic logic [7:0] merge(logic [7:0] o, logic [7:0] d, logic [1:0] m);
    return {m[1] ? d[7:4] : o[7:4], m[0] ? d[3:0] : o[3:0]};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_cycle();
    repeat (3) tick();
    strobe_man = 1'b1;
    tick();
    strobe_man = 1'b0;
  endtask

  // Random E strobe, about one clk in four.
  always @(posedge clk) begin
    #1;
    auto_q = ($urandom_range(0, 3) == 0);
  end

  // Memory responder: a fresh wait-state count per transaction.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wcnt >= cur_wait) begin
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      wcnt      = 0;
      cur_wait  = $urandom_range(wait_max, wait_min);
      mem_ready = (cur_wait == 0);
    end
  end

  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) tbmem[i] = init_val(i);
      init_done = 1'b1;
    end
    if (mem_req && mem_ready && mem_we) begin
      tbmem[mem_addr] = merge(tbmem[mem_addr], mem_wdata, mem_wmask);
    end
  end

  // Scoreboard monitor: memory completions and acknowledged accesses.
  always @(negedge clk) begin
    if (sb_en) begin
      if (mem_req && mem_ready) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", {mem_we, mem_addr}, 64'h0);
        end else begin
          mem_t e;
          e = mem_q.pop_front();
          check("mem_we", mem_we, e.we);
          check("mem_addr", mem_addr, e.addr);
          if (e.we) begin
            check("mem_wdata", mem_wdata, e.data);
            check("mem_wmask", mem_wmask, e.mask);
          end
        end
        if (mem_we) n_wr++;
        else n_rd++;
      end
      if (blt_ack && en_e_n) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", blt_ack, 1'b0);
        end else begin
          logic [7:0] exp_rd;
          exp_rd = ack_q.pop_front();
          check("ack_rdata", blt_rdata, exp_rd);
        end
      end
    end
  end

  task automatic open_session();
    blt_halt = 1'b1;
    ba = 1'b1;
    bs = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (blt_halt_ack) break;
    end
    check("session_grant", {blt_halt_ack, bus_owner}, 2'b11);
  endtask

  task automatic close_session();
    blt_halt = 1'b0;
    tick();
    check("session_release", {cpu_halt, blt_halt_ack, bus_owner}, 3'b000);
  endtask

  task automatic do_op(input bit is_rd, input logic [15:0] a, input logic [7:0] d,
                       input logic [1:0] m);
    bit got;
    if (is_rd) begin
      mem_q.push_back('{we: 1'b0, addr: a, data: 8'h00, mask: 2'b00});
      last_rd = refmem[a];
    end else if (m != 2'b00) begin
      mem_q.push_back('{we: 1'b1, addr: a, data: d, mask: m});
      refmem[a] = merge(refmem[a], d, m);
    end
    ack_q.push_back(last_rd);
    blt_rd      = is_rd;
    blt_wr      = !is_rd;
    blt_address = a;
    blt_wdata   = d;
    blt_nib     = m;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (blt_ack && en_e_n) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    blt_rd = 1'b0;
    blt_wr = 1'b0;
    if (!got) check("op_timeout", got, 1'b1);
  endtask

  initial begin
    int n;
    bit bad;
    int rd0, wr0;
    for (int i = 0; i < 65536; i++) refmem[i] = init_val(i);

    // Reset state
    tick();
    tick();
    check("reset_ctrl", {cpu_halt, blt_halt_ack, bus_owner, blt_ack, mem_req, mem_we}, 64'h0);
    check("reset_data", {mem_addr, mem_wdata, mem_wmask, blt_rdata}, 64'h0);
    rst = 1'b0;
    tick();

    // Grant handshake, steady BA/BS
    blt_halt = 1'b1;
    ba = 1'b1;
    bs = 1'b1;
    tick();
    check("cpu_halt_rise", cpu_halt, 1'b1);
    check("ack_not_early", blt_halt_ack, 1'b0);
    for (int k = 1; k <= 2; k++) begin
      strobe_cycle();
      check("grant_strobe", {blt_halt_ack, bus_owner}, (k == 2) ? 2'b11 : 2'b00);
    end
    blt_halt = 1'b0;
    tick();
    check("release", {cpu_halt, blt_halt_ack, bus_owner}, 3'b000);

    // Grant handshake, BS drops at strobe 2
    blt_halt = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      bs = (k != 2);
      strobe_cycle();
      check("grant_restart", {blt_halt_ack, bus_owner}, (k == 4) ? 2'b11 : 2'b00);
    end
    bs = 1'b1;

    // Read with three wait states
    wait_min = 3;
    wait_max = 3;
    tick();
    blt_rd = 1'b1;
    blt_address = 16'h9A40;
    n = 0;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (mem_req) begin
        n++;
        if (mem_we !== 1'b0 || mem_addr !== 16'h9A40) bad = 1'b1;
      end else if (n > 0) begin
        break;
      end
    end
    check("rd_req_cycles", n, 4);
    check("rd_req_fields", bad, 1'b0);
    check("rd_ack", blt_ack, 1'b1);
    check("rd_data", blt_rdata, 8'h5C);
    blt_rd = 1'b0;
    tick();
    tick();
    check("ack_hold", blt_ack, 1'b1);
    strobe_man = 1'b1;
    tick();
    strobe_man = 1'b0;
    check("ack_after_strobe", {blt_ack, blt_halt_ack}, 2'b01);
    check("rdata_held", blt_rdata, 8'h5C);

    // Masked write, zero-wait
    wait_min = 0;
    wait_max = 0;
    tick();
    blt_wr = 1'b1;
    blt_address = 16'h1234;
    blt_wdata = 8'hA7;
    blt_nib = 2'b10;
    tick();
    check("wr_fields", {mem_req, mem_we, mem_addr, mem_wdata, mem_wmask},
          {1'b1, 1'b1, 16'h1234, 8'hA7, 2'b10});
    blt_wr = 1'b0;
    refmem[16'h1234] = merge(refmem[16'h1234], 8'hA7, 2'b10);
    tick();
    check("wr_ack_2clk", {blt_ack, mem_req}, 2'b10);
    strobe_man = 1'b1;
    tick();
    strobe_man = 1'b0;
    blt_rd = 1'b1;
    blt_address = 16'h1234;
    tick();
    tick();
    blt_rd = 1'b0;
    check("wr_readback", {blt_ack, blt_rdata}, {1'b1, refmem[16'h1234]});
    strobe_man = 1'b1;
    tick();
    strobe_man = 1'b0;

    // Write with no nibble enables never reaches memory
    blt_wr = 1'b1;
    blt_nib = 2'b00;
    blt_address = 16'h5555;
    tick();
    check("nib0_ack", {blt_ack, mem_req}, 2'b10);
    blt_wr = 1'b0;
    strobe_man = 1'b1;
    tick();
    strobe_man = 1'b0;
    check("nib0_done", blt_ack, 1'b0);

    // Halt dropped during ACCESS still completes the access
    wait_min = 2;
    wait_max = 2;
    tick();
    blt_rd = 1'b1;
    blt_address = 16'h0042;
    tick();
    check("abort_access_req", mem_req, 1'b1);
    blt_halt = 1'b0;
    blt_rd = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (blt_ack) break;
    end
    check("abort_access_ack", {blt_ack, blt_rdata}, {1'b1, refmem[16'h0042]});
    strobe_man = 1'b1;
    tick();
    strobe_man = 1'b0;
    check("abort_access_idle", {cpu_halt, blt_halt_ack, bus_owner, blt_ack}, 4'b0000);

    // Halt dropped in HALT_REQ
    blt_halt = 1'b1;
    tick();
    check("halt_req_entry", cpu_halt, 1'b1);
    blt_halt = 1'b0;
    tick();
    check("halt_req_abort", {cpu_halt, blt_halt_ack}, 2'b00);

    // Reset during ACCESS
    blt_halt = 1'b1;
    tick();
    strobe_cycle();
    strobe_cycle();
    check("regrant", blt_halt_ack, 1'b1);
    wait_min = 3;
    wait_max = 3;
    tick();
    blt_rd = 1'b1;
    blt_address = 16'h0100;
    tick();
    check("rst_access_req", mem_req, 1'b1);
    rst = 1'b1;
    blt_rd = 1'b0;
    blt_halt = 1'b0;
    tick();
    check("rst_access_ctrl", {cpu_halt, blt_halt_ack, bus_owner, blt_ack, mem_req, mem_we}, 64'h0);
    check("rst_access_data", {mem_addr, mem_wdata, mem_wmask, blt_rdata}, 64'h0);
    rst = 1'b0;
    last_rd = 8'd0;
    tick();

    // Scoreboard phase: a 2x2 blit first, then random sessions
    sb_en = 1'b1;
    strobe_auto = 1'b1;
    wait_min = 0;
    wait_max = 0;
    rd0 = n_rd;
    wr0 = n_wr;
    open_session();
    for (int p = 0; p < 4; p++) begin
      do_op(1'b1, 16'h2000 + 16'(p), 8'h00, 2'b00);
      do_op(1'b0, 16'h3000 + 16'(p), 8'($urandom), 2'($urandom_range(1, 3)));
    end
    close_session();
    check("blit_reads", n_rd - rd0, 4);
    check("blit_writes", n_wr - wr0, 4);

    wait_max = 3;
    for (int s = 1; s <= 5; s++) begin
      open_session();
      for (int o = 0; o < 10; o++) begin
        do_op(1'($urandom), 16'h0400 * 16'(s) + 16'($urandom_range(0, 7)),
              8'($urandom), 2'($urandom_range(0, 3)));
      end
      close_session();
    end
    tick();
    check("queues_empty", mem_q.size() + ack_q.size(), 0);
    sb_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
